// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-stage results and control in, register-file write port and halt status out.
interface mem_wb_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic          in_reg_write;
  logic [RW-1:0] in_dst_reg;
  logic [2:0]    in_wb_sel;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_mem_data;
  logic [DW-1:0] in_pc_plus2;
  logic [7:0]    in_imm8;
  logic [DW-1:0] in_old_rd;
  logic          in_halt;
  logic          wb_valid;
  logic          wb_write_en;
  logic [RW-1:0] wb_reg_id;
  logic [DW-1:0] wb_data;
  logic          halted;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_dst_reg, in_wb_sel,
           in_alu_result, in_mem_data, in_pc_plus2, in_imm8, in_old_rd, in_halt,
    input  wb_valid, wb_write_en, wb_reg_id, wb_data, halted
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_dst_reg, in_wb_sel,
           in_alu_result, in_mem_data, in_pc_plus2, in_imm8, in_old_rd, in_halt,
    output wb_valid, wb_write_en, wb_reg_id, wb_data, halted
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: selects/merges writeback data, qualifies the register-file write, retires HLT.
//   state     | meaning
//   ST_RUN    | normal operation, valid instructions load and may write
//   ST_HALTED | HLT has retired, every further load becomes a bubble
module mem_wb_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  mem_wb_if.slave  bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_halted;
  logic          w_run;

  logic          r_valid;
  logic          r_write_en;
  logic [RW-1:0] r_reg_id;
  logic [DW-1:0] r_data;

  logic          w_sel_legal;
  logic [DW-1:0] w_sel_data;
  logic          w_load_valid;
  logic          w_write_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:
        if (!bus.flush && !bus.stall && bus.in_valid && bus.in_halt)
          w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_halted = 1'b0;
    w_run    = 1'b0;
    case (r_state)
      ST_RUN:    w_run    = 1'b1;
      ST_HALTED: w_halted = 1'b1;
      default:   w_run    = 1'b1;
    endcase
  end

  // LLB/LHB merge the immediate into the current destination value supplied upstream.
  always_comb begin
    w_sel_legal = 1'b1;
    w_sel_data  = '0;
    case (bus.in_wb_sel)
      3'd0: w_sel_data = bus.in_alu_result;
      3'd1: w_sel_data = bus.in_mem_data;
      3'd2: w_sel_data = bus.in_pc_plus2;
      3'd3: w_sel_data = {bus.in_old_rd[DW-1:8], bus.in_imm8};
      3'd4: w_sel_data = {bus.in_imm8, bus.in_old_rd[7:0]};
      default: begin
        w_sel_legal = 1'b0;
        w_sel_data  = '0;
      end
    endcase
  end

  // HLT occupies the stage as a valid instruction but never writes; R0 is never written.
  assign w_load_valid = bus.in_valid & w_run;
  assign w_write_en   = w_load_valid & bus.in_reg_write & (bus.in_dst_reg != '0)
                      & w_sel_legal & ~bus.in_halt;

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.flush) begin
      r_valid    <= 1'b0;
      r_write_en <= 1'b0;
      r_reg_id   <= '0;
      r_data     <= '0;
    end else if (!bus.stall) begin
      r_valid    <= w_load_valid;
      r_write_en <= w_write_en;
      r_reg_id   <= w_load_valid ? bus.in_dst_reg : '0;
      r_data     <= w_load_valid ? w_sel_data : '0;
    end
  end

  assign bus.wb_valid    = r_valid;
  assign bus.wb_write_en = r_write_en;
  assign bus.wb_reg_id   = r_reg_id;
  assign bus.wb_data     = r_data;
  assign bus.halted      = w_halted;

endmodule
